// File: rtl/xera4_video_scan.sv
// Purpose: 640x480@60 VGA scan-out of a 1 bpp 320x240 bitmap (2x2 doubled) read from video RAM port B.
// Latency: sync/de/rgb/frame_irq are registered and reflect the previous clk's hcnt/vcnt; RAM reads take 1 clk.
// Backpressure: none; the scan free-runs, and port writes are level-sampled and never stalled.
// Ports:
//   clk, rst                   - pixel clock, asynchronous active-high reset
//   port_add/port_out/port_we  - CPU port bus; registers at PORT_BASE..PORT_BASE+3 (BASE_LO, BASE_HI, FG, BG)
//   vid_addr/vid_data          - video RAM read port (data valid one clk after address)
//   hsync/vsync/de/rgb         - VGA outputs (syncs active-low, rgb is RGB332 and 0 outside the visible area)
//   frame_irq                  - one-clk pulse when vertical blanking starts
module xera4_video_scan #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [15:0] PORT_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] port_add,
    input  logic [7:0]  port_out,
    input  logic        port_we,
    output logic [14:0] vid_addr,
    input  logic [7:0]  vid_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  rgb,
    output logic        frame_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PREFETCH  = HW'(H_TOTAL - 3);
    localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_FETCH_END = HW'(H_ACTIVE - 3);
    localparam logic [HW-1:0] HS_START    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END      = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END      = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0]   ROW_BYTES   = 15'(H_ACTIVE / 16);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [7:0]    base_lo_q, base_lo_d;
    logic [6:0]    base_hi_q, base_hi_d;
    logic [7:0]    fg_q, fg_d;
    logic [7:0]    bg_q, bg_d;
    logic [14:0]   frame_base_q, frame_base_d;
    logic [14:0]   vid_addr_q, vid_addr_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          frame_irq_q, frame_irq_d;

    logic [15:0]   port_off;
    logic [VW-1:0] next_line;
    logic          fetch_en;
    logic [VW-1:0] fetch_line;
    logic [HW-1:0] fetch_col;
    logic          visible;

    always_comb begin
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        base_lo_d    = base_lo_q;
        base_hi_d    = base_hi_q;
        fg_d         = fg_q;
        bg_d         = bg_q;
        frame_base_d = frame_base_q;
        vid_addr_d   = vid_addr_q;
        shreg_d      = shreg_q;
        port_off     = port_add - PORT_BASE;
        next_line    = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        fetch_en     = 1'b0;
        fetch_line   = vcnt_q;
        fetch_col    = '0;
        visible      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);

        // Raster counters
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = next_line;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end

        // Register writes; the subtraction wraps, so addresses below PORT_BASE land far above 3
        if (port_we && (port_off < 16'd4)) begin
            case (port_off[1:0])
                2'd0:    base_lo_d = port_out;
                2'd1:    base_hi_d = port_out[6:0];
                2'd2:    fg_d      = port_out;
                default: bg_d      = port_out;
            endcase
        end

        // Base is shadowed on the last line so a frame never mixes two bases
        if ((hcnt_q == '0) && (vcnt_q == V_LAST)) begin
            frame_base_d = {base_hi_q, base_lo_q};
        end

        // Address is registered here so it appears at hcnt = 16k-2; the byte comes back at 16k-1
        // and is loaded into the shifter on that edge, ready for pixel 16k.
        if (hcnt_q == H_PREFETCH) begin
            if (next_line < V_ACT) begin
                fetch_en   = 1'b1;
                fetch_line = next_line;
            end
        end else if ((hcnt_q[3:0] == 4'd13) && (hcnt_q < H_FETCH_END) && (vcnt_q < V_ACT)) begin
            fetch_en  = 1'b1;
            fetch_col = (hcnt_q + HW'(3)) >> 4;
        end
        if (fetch_en) begin
            vid_addr_d = frame_base_q + 15'(fetch_line >> 1) * ROW_BYTES + 15'(fetch_col);
        end

        // Load every 16 clks (bytes fetched past the visible area are harmless: rgb is blanked);
        // otherwise shift on odd hcnt so each source bit covers two screen pixels.
        if ((hcnt_q[3:0] == 4'hF) || (hcnt_q == H_LAST)) begin
            shreg_d = vid_data;
        end else if (hcnt_q[0]) begin
            shreg_d = {shreg_q[6:0], 1'b0};
        end

        hsync_d     = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vsync_d     = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        de_d        = visible;
        rgb_d       = visible ? (shreg_q[7] ? fg_q : bg_q) : 8'h00;
        frame_irq_d = (hcnt_q == '0) && (vcnt_q == V_ACT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            base_lo_q    <= 8'h00;
            base_hi_q    <= 7'h00;
            fg_q         <= 8'hFF;
            bg_q         <= 8'h00;
            frame_base_q <= 15'h0000;
            vid_addr_q   <= 15'h0000;
            shreg_q      <= 8'h00;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            de_q         <= 1'b0;
            rgb_q        <= 8'h00;
            frame_irq_q  <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            base_lo_q    <= base_lo_d;
            base_hi_q    <= base_hi_d;
            fg_q         <= fg_d;
            bg_q         <= bg_d;
            frame_base_q <= frame_base_d;
            vid_addr_q   <= vid_addr_d;
            shreg_q      <= shreg_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            frame_irq_q  <= frame_irq_d;
        end
    end

    assign vid_addr  = vid_addr_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign rgb       = rgb_q;
    assign frame_irq = frame_irq_q;

endmodule

// File: tb/tb_xera4_video_scan.sv
// Bench for xera4_video_scan: shortened vertical/horizontal blanking keeps frames small, while the
// 640-pixel line (40 bytes per source row) is kept so the bitmap layout is the real one.
module tb_xera4_video_scan;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 8;
    localparam int H_SYNC   = 16;
    localparam int H_BP     = 16;
    localparam int V_ACTIVE = 12;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] PB = 16'hFF00;
    localparam int BOUND    = HT * VT + 20;

    logic        clk;
    logic        rst;
    logic [15:0] port_add;
    logic [7:0]  port_out;
    logic        port_we;
    logic [14:0] vid_addr;
    logic [7:0]  vid_data;
    logic        hsync, vsync, de, frame_irq;
    logic [7:0]  rgb;

    xera4_video_scan #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PORT_BASE(PB)
    ) dut (
        .clk(clk), .rst(rst),
        .port_add(port_add), .port_out(port_out), .port_we(port_we),
        .vid_addr(vid_addr), .vid_data(vid_data),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_irq(frame_irq)
    );

    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Video RAM: registered read, data one clk after the address
    logic [7:0] ram [0:32767];
    initial vid_data = 8'h00;
    always @(posedge clk) vid_data <= ram[vid_addr];

    // ---------------- behavioural model ----------------
    int          pos;           // raster position the DUT counters hold after the last edge
    int          mh, mv;
    logic [14:0] m_base;
    logic [14:0] m_fb;
    logic [7:0]  m_fg, m_bg;
    logic [14:0] m_vaddr;
    logic        first_line;
    logic        exp_hs, exp_vs, exp_de, exp_irq, chk_rgb;
    logic [7:0]  exp_rgb;

    function automatic logic [14:0] fetch_addr(input int line, input int col);
        int a;
        a = int'(m_fb) + 40 * (line / 2) + col;
        return 15'(a % 32768);
    endfunction

    function automatic logic [7:0] pixel_colour(input int x, input int y);
        logic [7:0] b;
        int         idx;
        b   = ram[fetch_addr(y, x / 16)];
        idx = 7 - ((x / 2) % 8);
        return b[idx] ? m_fg : m_bg;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos = 0; m_base = '0; m_fb = '0; m_fg = 8'hFF; m_bg = 8'h00; m_vaddr = '0;
            first_line = 1'b1;
            exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_irq = 1'b0; exp_rgb = 8'h00;
            chk_rgb = 1'b0;
        end else begin
            mh = pos % HT;
            mv = pos / HT;
            exp_hs  = !(mh >= H_ACTIVE + H_FP && mh < H_ACTIVE + H_FP + H_SYNC);
            exp_vs  = !(mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC);
            exp_de  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
            exp_irq = (mh == 0) && (mv == V_ACTIVE);
            if (mv != 0) first_line = 1'b0;
            chk_rgb = !first_line;
            exp_rgb = exp_de ? pixel_colour(mh, mv) : 8'h00;
            if (mh == 0 && mv == VT - 1) m_fb = m_base;
            if (port_we) begin
                if (port_add == PB)              m_base[7:0]  = port_out;
                else if (port_add == PB + 16'd1) m_base[14:8] = port_out[6:0];
                else if (port_add == PB + 16'd2) m_fg = port_out;
                else if (port_add == PB + 16'd3) m_bg = port_out;
            end
            pos = (pos + 1) % (HT * VT);
            mh = pos % HT;
            mv = pos / HT;
            // address visible while the counters sit at 16k-2 (k>=1) or at HT-2 for the next line's byte 0
            if (mv < V_ACTIVE && (mh % 16) == 14 && mh < H_ACTIVE - 2)
                m_vaddr = fetch_addr(mv, (mh + 2) / 16);
            if (mh == HT - 2 && ((mv + 1) % VT) < V_ACTIVE)
                m_vaddr = fetch_addr((mv + 1) % VT, 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (pos h=%0d v=%0d)", name, act, expv, pos % HT, pos / HT);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("hsync", 32'(hsync), 32'(exp_hs));
            chk("vsync", 32'(vsync), 32'(exp_vs));
            chk("de", 32'(de), 32'(exp_de));
            chk("frame_irq", 32'(frame_irq), 32'(exp_irq));
            chk("vid_addr", 32'(vid_addr), 32'(m_vaddr));
            if (chk_rgb) chk("rgb", 32'(rgb), 32'(exp_rgb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos(input int th, input int tv);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((pos % HT) == th && (pos / HT) == tv) && n < BOUND);
        if (n >= BOUND) chk("wait_pos_timeout", 32'(n), 32'(0));
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [7:0] d, input int n);
        @(negedge clk);
        port_add = a;
        port_out = d;
        port_we  = 1'b1;
        repeat (n) @(negedge clk);
        port_we  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_rgb"}, 32'(rgb), 32'd0);
        chk({tag, "_irq"}, 32'(frame_irq), 32'd0);
        chk({tag, "_vaddr"}, 32'(vid_addr), 32'd0);
    endtask

    logic [7:0] lit [16];
    int n, w;

    initial begin
        lit = '{8'hE0, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'hE0, 8'h03, 8'h03,
                8'h03, 8'h03, 8'hE0, 8'hE0, 8'h03, 8'h03, 8'hE0, 8'hE0};
        for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
        ram[16'h1000] = 8'hA5;
        rst = 1'b1; port_add = 16'h0000; port_out = 8'h00; port_we = 1'b0;
        #50;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // frame 0: program base 0x1000 (bit 7 of BASE_HI ignored) and colours
        wait_pos(0, 3);
        write_reg(PB, 8'h00, 1);
        write_reg(PB + 16'd1, 8'h90, 1);
        write_reg(PB + 16'd2, 8'hE0, 1);
        write_reg(PB + 16'd3, 8'h03, 1);
        wait_pos(HT - 2, VT - 1);
        chk("prefetch_0x1000", 32'(vid_addr), 32'h1000);

        // frame 1: first 16 pixels of lines 0 and 1
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 16; x++) begin
                wait_pos(x + 1, y);
                chk($sformatf("pix_l%0d_x%0d", y, x), 32'(rgb), 32'(lit[x]));
            end
        end

        // mid-frame base change only affects the next frame
        wait_pos(0, 6);
        write_reg(PB + 16'd1, 8'h20, 1);
        wait_pos(HT - 2, VT - 1);
        chk("prefetch_0x2000", 32'(vid_addr), 32'h2000);

        // frame 2: base near the top of the address space
        wait_pos(0, 3);
        write_reg(PB, 8'hF0, 1);
        write_reg(PB + 16'd1, 8'h7F, 1);
        wait_pos(16 * 16 - 2, 0);
        chk("wrap_col16", 32'(vid_addr), 32'h0000);
        wait_pos(HT - 2, 1);
        chk("wrap_row1_col0", 32'(vid_addr), 32'h0018);

        // decode: neighbours of the register window are ignored; held strobe on FG
        write_reg(PB + 16'd4, 8'h55, 1);
        write_reg(PB - 16'd1, 8'h55, 1);
        write_reg(PB + 16'd2, 8'h1C, 3);

        // asynchronous reset in the middle of a line
        wait_pos(300, 4);
        #5 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hsync !== 1'b0 && n < 2000);
        chk("hsync_first_low", 32'(n), 32'(H_ACTIVE + H_FP + 1));
        w = 0;
        while (hsync === 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("hsync_width", 32'(w), 32'(H_SYNC));
        wait_pos(HT - 2, VT - 1);
        chk("prefetch_after_reset", 32'(vid_addr), 32'h0000);
        wait_pos(5, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(40 * 95000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
